// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals between the CPU memory stage,
// the load/store unit and the word-wide data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  // Environment side: drives requests and memory read data.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_wen
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide memory with one-cycle read
// latency. Sub-word stores are done as read-modify-write of the whole word.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 131072
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP, ERR} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        is_half, is_word, bad_funct, req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data, merge_data;

  // Classify the incoming request and decide whether it must be rejected.
  always_comb begin
    is_half = (bus.req_funct3[1:0] == 2'b01);
    is_word = (bus.req_funct3 == 3'b010);
    if (bus.req_we) begin
      bad_funct = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      bad_funct = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    req_err = bad_funct
            | (is_half & bus.req_addr[0])
            | (is_word & (|bus.req_addr[1:0]))
            | (bus.req_addr >= 32'(MEM_BYTES));
  end

  // State and latched request; reset aborts whatever access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next state; the request is captured only when accepted in IDLE.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (req_err)          state_d = ERR;
          else if (!bus.req_we) state_d = RD;
          else if (is_word)     state_d = WR;
          else                  state_d = RD;
        end
      end
      RD:         state_d = we_q ? MERGE : RESP;
      MERGE, WR:  state_d = RESP;
      RESP, ERR:  state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs: lane extraction for loads, lane merge for sub-word stores, and
  // all strobes forced quiet while reset is asserted.
  always_comb begin
    lane_byte  = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half  = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'h0, lane_byte};
      3'b101:  load_data = {16'h0, lane_half};
      default: load_data = bus.mem_rdata;
    endcase

    merge_data = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    bus.mem_addr   = {addr_q[31:2], 2'b00};
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.mem_wen    = 1'b0;
    bus.mem_wdata  = 32'h0;
    if (rst) begin
      bus.req_ready = 1'b1;
    end else begin
      case (state_q)
        IDLE: bus.req_ready = 1'b1;
        WR: begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = wdata_q;
        end
        MERGE: begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = merge_data;
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = we_q ? 32'h0 : load_data;
        end
        ERR: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level reference model
// predicts every response and memory write, a per-cycle monitor compares,
// and literal expectations pin the known-answer cases.
module tb_load_store_unit;
  localparam int unsigned MEM_BYTES = 131072;
  localparam int WORDS = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  load_store_unit_if bus_if ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [31:0] tb_mem  [WORDS];
  logic [31:0] ref_mem [WORDS];

  int n_checks = 0;
  int n_fail = 0;
  int acc_count = 0;
  int resp_count = 0;
  int wen_count = 0;
  logic busy = 1'b0;
  logic last_err = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  // Data memory with registered read and full-word write.
  always @(posedge clk) begin
    if (bus_if.mem_wen) tb_mem[bus_if.mem_addr[16:2]] <= bus_if.mem_wdata;
    bus_if.mem_rdata <= tb_mem[bus_if.mem_addr[16:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model and per-cycle comparison, sampled on the falling edge.
  initial begin : monitor
    int k, lat, sh;
    logic exp_err, exp_store_wr;
    logic [2:0] f;
    logic [31:0] a, w, lane, exp_rdata, exp_waddr, exp_wdata;
    k = 0; lat = 0;
    exp_err = 1'b0; exp_store_wr = 1'b0;
    exp_rdata = 32'h0; exp_waddr = 32'h0; exp_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_wen) begin
        wen_count++;
        last_wr_addr = bus_if.mem_addr;
        last_wr_data = bus_if.mem_wdata;
      end
      if (rst) begin
        checkOutput("rst req_ready", 32'(bus_if.req_ready), 32'd1);
        checkOutput("rst resp_valid", 32'(bus_if.resp_valid), 32'd0);
        checkOutput("rst resp_err", 32'(bus_if.resp_err), 32'd0);
        checkOutput("rst resp_rdata", bus_if.resp_rdata, 32'h0);
        checkOutput("rst mem_wen", 32'(bus_if.mem_wen), 32'd0);
        checkOutput("rst mem_wdata", bus_if.mem_wdata, 32'h0);
        busy = 1'b0;
      end else if (busy) begin
        k++;
        checkOutput("busy req_ready", 32'(bus_if.req_ready), 32'd0);
        checkOutput("resp_valid timing", 32'(bus_if.resp_valid), 32'(k == lat));
        checkOutput("mem_wen timing", 32'(bus_if.mem_wen), 32'(exp_store_wr && (k == lat - 1)));
        if (exp_store_wr && (k == lat - 1)) begin
          checkOutput("mem_wdata", bus_if.mem_wdata, exp_wdata);
          ref_mem[exp_waddr[16:2]] = exp_wdata;
        end else begin
          checkOutput("mem_wdata quiet", bus_if.mem_wdata, 32'h0);
        end
        if (!exp_err) checkOutput("mem_addr", bus_if.mem_addr, exp_waddr);
        if (k == lat) begin
          checkOutput("resp_err", 32'(bus_if.resp_err), 32'(exp_err));
          checkOutput("resp_rdata", bus_if.resp_rdata, exp_rdata);
          last_err = bus_if.resp_err;
          last_rdata = bus_if.resp_rdata;
          resp_count++;
          busy = 1'b0;
        end
      end else begin
        checkOutput("idle req_ready", 32'(bus_if.req_ready), 32'd1);
        checkOutput("idle resp_valid", 32'(bus_if.resp_valid), 32'd0);
        checkOutput("idle resp_rdata", bus_if.resp_rdata, 32'h0);
        checkOutput("idle mem_wen", 32'(bus_if.mem_wen), 32'd0);
        checkOutput("idle mem_wdata", bus_if.mem_wdata, 32'h0);
        if (bus_if.req_valid) begin
          a = bus_if.req_addr;
          f = bus_if.req_funct3;
          exp_err = 1'b0;
          if (a >= MEM_BYTES) exp_err = 1'b1;
          if (bus_if.req_we) begin
            if (f > 3'd2) exp_err = 1'b1;
          end else if (f == 3'd3 || f > 3'd5) begin
            exp_err = 1'b1;
          end
          if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) exp_err = 1'b1;
          if (f == 3'd2 && (a % 4 != 0)) exp_err = 1'b1;
          w = ref_mem[a[16:2]];
          sh = int'(a % 4) * 8;
          exp_waddr = a - (a % 4);
          exp_rdata = 32'h0;
          exp_wdata = 32'h0;
          exp_store_wr = bus_if.req_we && !exp_err;
          if (exp_err) lat = 1;
          else if (!bus_if.req_we || f == 3'd2) lat = 2;
          else lat = 3;
          if (!bus_if.req_we && !exp_err) begin
            case (f)
              3'd0: begin lane = (w >> sh) & 32'hFF;   exp_rdata = (lane >= 128)   ? lane - 32'd256   : lane; end
              3'd1: begin lane = (w >> sh) & 32'hFFFF; exp_rdata = (lane >= 32768) ? lane - 32'd65536 : lane; end
              3'd4: exp_rdata = (w >> sh) & 32'hFF;
              3'd5: exp_rdata = (w >> sh) & 32'hFFFF;
              default: exp_rdata = w;
            endcase
          end
          if (exp_store_wr) begin
            case (f)
              3'd0: exp_wdata = (w & ~(32'hFF << sh))   | ((bus_if.req_wdata & 32'hFF) << sh);
              3'd1: exp_wdata = (w & ~(32'hFFFF << sh)) | ((bus_if.req_wdata & 32'hFFFF) << sh);
              default: exp_wdata = bus_if.req_wdata;
            endcase
          end
          k = 0;
          busy = 1'b1;
          acc_count++;
        end
      end
    end
  end

  // Issue one request, wait for acceptance and for its completion.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int guard;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b1;
    bus_if.req_we = we;
    bus_if.req_funct3 = f3;
    bus_if.req_addr = addr;
    bus_if.req_wdata = wdata;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(bus_if.req_ready && !rst) && guard < 20);
    checkOutput("accept within bound", 32'(guard < 20), 32'd1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("response within bound", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int w0, a0, r0;
    for (int i = 0; i < WORDS; i++) begin
      tb_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    tb_mem[32'h100 >> 2] = 32'h8899AABB;
    ref_mem[32'h100 >> 2] = 32'h8899AABB;

    // Reset with a request pending: it must not be taken.
    rst = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_we = 1'b0;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr = 32'h100;
    bus_if.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.req_valid = 1'b0;
    checkOutput("no accept during reset", 32'(acc_count), 32'd0);
    @(negedge clk);
    checkOutput("mem_addr after reset", bus_if.mem_addr, 32'h0);

    // Loads from the preloaded word.
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0);
    checkOutput("LB 0x103", last_rdata, 32'hFFFFFF88);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0);
    checkOutput("LBU 0x103", last_rdata, 32'h00000088);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("LW 0x100", last_rdata, 32'h8899AABB);
    applyStimulus(1'b0, 3'b001, 32'h102, 32'h0);
    checkOutput("LH 0x102", last_rdata, 32'hFFFF8899);
    applyStimulus(1'b0, 3'b101, 32'h100, 32'h0);
    checkOutput("LHU 0x100", last_rdata, 32'h0000AABB);

    // Rejected requests never write.
    w0 = wen_count;
    applyStimulus(1'b0, 3'b001, 32'h101, 32'h0);
    checkOutput("LH 0x101 err", 32'(last_err), 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h102, 32'h0);
    checkOutput("LW 0x102 err", 32'(last_err), 32'd1);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0);
    checkOutput("load funct3 011 err", 32'(last_err), 32'd1);
    applyStimulus(1'b1, 3'b100, 32'h100, 32'h11223344);
    checkOutput("store funct3 100 err", 32'(last_err), 32'd1);
    checkOutput("no writes on errors", 32'(wen_count), 32'(w0));

    // Byte store by read-modify-write, then readback.
    w0 = wen_count;
    applyStimulus(1'b1, 3'b000, 32'h101, 32'h12345677);
    checkOutput("SB one pulse", 32'(wen_count - w0), 32'd1);
    checkOutput("SB mem_addr", last_wr_addr, 32'h100);
    checkOutput("SB mem_wdata", last_wr_data, 32'h889977BB);
    checkOutput("SB resp_err", 32'(last_err), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("LW after SB", last_rdata, 32'h889977BB);

    // Top legal word and first illegal word.
    applyStimulus(1'b1, 3'b010, 32'h1FFFC, 32'hDEADBEEF);
    checkOutput("SW 0x1FFFC err", 32'(last_err), 32'd0);
    checkOutput("SW 0x1FFFC data", last_wr_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h1FFFC, 32'h0);
    checkOutput("LW 0x1FFFC", last_rdata, 32'hDEADBEEF);
    w0 = wen_count;
    applyStimulus(1'b1, 3'b010, 32'h20000, 32'hCAFEF00D);
    checkOutput("SW 0x20000 err", 32'(last_err), 32'd1);
    checkOutput("SW 0x20000 no write", 32'(wen_count), 32'(w0));

    // Reset during the merge cycle of a half store aborts it.
    w0 = wen_count;
    r0 = resp_count;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b1;
    bus_if.req_we = 1'b1;
    bus_if.req_funct3 = 3'b001;
    bus_if.req_addr = 32'h102;
    bus_if.req_wdata = 32'h5555CAFE;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort ready", 32'(bus_if.req_ready), 32'd1);
    checkOutput("abort no write", 32'(wen_count), 32'(w0));
    checkOutput("abort no resp", 32'(resp_count), 32'(r0));
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("LW after abort", last_rdata, 32'h889977BB);

    // Completed half store and a signed byte read of it.
    applyStimulus(1'b1, 3'b001, 32'h102, 32'h1234CAFE);
    checkOutput("SH 0x102 data", last_wr_data, 32'hCAFE77BB);
    applyStimulus(1'b0, 3'b000, 32'h102, 32'h0);
    checkOutput("LB 0x102", last_rdata, 32'hFFFFFFFE);

    // Request held for six cycles: accepted in cycles 0 and 3 only.
    a0 = acc_count;
    r0 = resp_count;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b1;
    bus_if.req_we = 1'b0;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr = 32'h100;
    repeat (6) @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    checkOutput("held valid accepts", 32'(acc_count - a0), 32'd2);
    checkOutput("held valid responses", 32'(resp_count - r0), 32'd2);
    checkOutput("held valid rdata", last_rdata, 32'hCAFE77BB);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, 131072, size of the byte-addressed data memory; requests with req_addr >= MEM_BYTES are errors.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU memory-stage request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_err  output  1  valid with resp_valid; 1 = rejected request.
REQ-012 resp_rdata  output  32  extended load result; 0 when resp_valid=0, for stores, or on error.
REQ-013 mem_addr  output  32  word-aligned address to data memory ({req_addr[31:2],2'b00}).
REQ-014 mem_wdata  output  32  full-word write data; 0 when mem_wen=0.
REQ-015 mem_wen  output  1  full-word write strobe.
REQ-016 mem_rdata  input  32  memory read data, registered (1-cycle latency from mem_addr); byte at mem_addr in [7:0], little-endian.

Function
REQ-017 States: IDLE, RD, MERGE, WR, RESP, ERR; req_ready=1 only in IDLE.
REQ-018 Accept = req_valid && req_ready at a rising edge; request fields latched; req_* ignored while busy.
REQ-019 Error on accept if: H at addr[0]!=0; W at addr[1:0]!=0; req_addr >= MEM_BYTES; funct3 undefined for the direction (stores: only 000/001/010) -> IDLE->ERR.
REQ-020 ERR: resp_valid=1, resp_err=1, resp_rdata=0, mem_wen=0; -> IDLE.
REQ-021 Load: IDLE->RD->RESP; mem_addr held through RD and RESP; resp_valid in RESP, i.e. 2 cycles after the accepting edge.
REQ-022 Load extraction in RESP, from mem_rdata, lane = addr[1:0] (B) or addr[1] (H); B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-023 SW: IDLE->WR->RESP; WR drives mem_wen=1 and mem_wdata=req_wdata for exactly one cycle.
REQ-024 SB/SH: IDLE->RD->MERGE->RESP; MERGE drives mem_wen=1, mem_wdata=mem_rdata with the addressed lane(s) replaced by req_wdata[7:0]/[15:0]; other bytes unchanged.
REQ-025 Stores: resp_valid=1, resp_err=0, resp_rdata=0 in RESP; SW latency 2, SB/SH latency 3.
REQ-026 RESP->IDLE unconditionally; no response backpressure; next request accepted at the earliest in the cycle after RESP.
REQ-027 mem_wen asserted only in WR or MERGE and never while rst=1.
REQ-028 Exactly one mem_wen pulse per accepted non-error store; zero for loads and errors.
REQ-029 Address wrap: none; aligned word at MEM_BYTES-4 is legal; no access touches two words.

Reset
REQ-030 While rst=1 at a rising edge: state->IDLE, latched request cleared, mem_addr=0.
REQ-031 During and after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wdata=0, mem_wen=0.
REQ-032 Reset mid-operation aborts the access: no mem_wen, no resp_valid for it; a req_valid in the rst cycle is not accepted.

Verification (word 0x100 preloaded 0x8899AABB)
REQ-033 LB 0x103 -> resp_valid 2 cycles after accept, resp_rdata=0xFFFFFF88; LBU 0x103 -> 0x00000088; LW 0x100 -> 0x8899AABB.
REQ-034 LH 0x102 -> 0xFFFF8899; LHU 0x100 -> 0x0000AABB; LH 0x101 -> ERR next cycle, resp_err=1, mem_wen never asserted.
REQ-035 SB 0x101 wdata 0x12345677 -> one mem_wen pulse, mem_addr=0x100, mem_wdata=0x889977BB, resp 3 cycles after accept; readback LW=0x889977BB.
REQ-036 MEM_BYTES=131072: SW 0x1FFFC wdata 0xDEADBEEF -> written, resp_err=0; SW 0x20000 -> resp_err=1, no write.
REQ-037 rst asserted in MERGE cycle of SH 0x102 -> mem_wen=0 that cycle, no resp_valid, req_ready=1 next cycle, memory word unchanged.
REQ-038 req_valid held high for 6 cycles with LW 0x100 -> exactly 2 acceptances (cycles 0 and 3), 2 resp_valid pulses.
